lsu_bus_bridge: RTL and testbench

Load/store bridge between the single-cycle datapath's data-memory port and an external handshaked memory bus. Replaces the zero-latency data memory: it latches each load/store, drives byte lanes from F3, waits for the bus, and stalls the datapath (PC and register write held) until the access completes. Load data returns sign- or zero-extended, ready for the register write-back mux.

---
 rtl/lsu_bus_bridge_pkg.sv | 35 +++
 rtl/lsu_bus_bridge_if.sv | 32 +++
 rtl/lsu_bus_bridge_lane.sv | 64 ++++++
 rtl/lsu_bus_bridge.sv | 178 +++++++++++++++++
 tb/tb_lsu_bus_bridge.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_bus_bridge_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store bus bridge: the FSM state type,
// funct3 encodings for loads and stores, the default response timeout, and a
// helper that flags funct3 codes that have no load/store meaning.
// ---------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } lsu_state_e;

    // Load encodings (inst[14:12])
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store encodings share the size field with the loads
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int LSU_TIMEOUT_DEFAULT = 16;

    // Codes 011, 110 and 111 never issue a bus access
    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_bus_bridge_if.sv
// ---------------------------------------------------------------------------
// lsu_bus_bridge_if
// Handshaked memory bus between the bridge (master) and memory (slave).
//   bus_req/bus_gnt       : request and its acceptance
//   bus_addr/bus_we       : word-aligned address, write flag
//   bus_be/bus_wdata      : byte enables and lane-aligned store data
//   bus_rvalid            : response strobe (read data or write ack)
//   bus_rdata/bus_err     : read word and error, qualified by bus_rvalid
// ---------------------------------------------------------------------------
interface lsu_bus_bridge_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_gnt;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_we;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_rvalid;
    logic [31:0]       bus_rdata;
    logic              bus_err;

    modport master (
        output bus_req, bus_addr, bus_we, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata, bus_err
    );

    modport slave (
        input  bus_req, bus_addr, bus_we, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata, bus_err
    );
endinterface

// File: rtl/lsu_bus_bridge_lane.sv
// ---------------------------------------------------------------------------
// lsu_lane
// Combinational byte-lane logic for the bridge.
//   f3         in  : funct3 of the access (size in [1:0], unsigned in [2])
//   addr_lo    in  : byte offset within the word
//   wdata      in  : store data from rs2
//   rdata_word in  : word returned by the bus
//   be         out : byte enables for the access size/offset
//   wdata_lane out : store data replicated onto every candidate lane
//   load_data  out : selected lane, sign- or zero-extended
// ---------------------------------------------------------------------------
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  f3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_word,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    logic [31:0] byte_shifted;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Replicating the store data means the memory picks the right copy from
    // the enables alone, so no shifter is needed on the write path.
    always_comb begin
        be         = 4'b0000;
        wdata_lane = 32'h0;
        case (f3[1:0])
            2'b00: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            2'b01: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
            end
            default: begin
                be         = 4'b1111;
                wdata_lane = wdata;
            end
        endcase
    end

    // Halfwords only look at addr_lo[1], so a stray a[0] is ignored here.
    always_comb begin
        byte_shifted = rdata_word >> {addr_lo, 3'b000};
        byte_val     = byte_shifted[7:0];
        half_val     = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];
        case (f3)
            F3_LB:   load_data = {{24{byte_val[7]}}, byte_val};
            F3_LBU:  load_data = {24'h0, byte_val};
            F3_LH:   load_data = {{16{half_val[15]}}, half_val};
            F3_LHU:  load_data = {16'h0, half_val};
            F3_LW:   load_data = rdata_word;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_bus_bridge.sv
// ---------------------------------------------------------------------------
// lsu_bus_bridge
// Bridges the single-cycle datapath's data-memory port to a handshaked bus.
// Each load/store is latched, issued on the bus, and the datapath is stalled
// until the response (or a timeout) completes it with a one-cycle done pulse.
//   clk, rst            : clock, asynchronous active-low reset
//   req_valid/req_we    : load/store request, store flag
//   req_f3/req_addr     : funct3 and byte address
//   req_wdata           : store data
//   stall               : hold PC and register write
//   done/err/rdata      : completion pulse, error flag, extended load data
//   bus                 : master side of lsu_bus_bridge_if
// Build option: define LSU_MISALIGN_TRAP_EN to complete misaligned halfword
// and word accesses with an error instead of performing them aligned.
// ---------------------------------------------------------------------------
module lsu_bus_bridge
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_f3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    lsu_bus_bridge_if.master  bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_e       state;
    logic             lat_we;
    logic [2:0]       lat_f3;
    logic [1:0]       lat_lo;
    logic [CNT_W-1:0] tmo_cnt;
    logic             timeout_hit;
    logic             req_bad;

    logic [2:0]       lane_f3;
    logic [1:0]       lane_lo;
    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata;
    logic [31:0]      lane_load;

    // In IDLE the lane logic formats the incoming request for the bus; once
    // the access is underway it extracts load data using the latched f3/offset.
    assign lane_f3 = (state == ST_IDLE) ? req_f3 : lat_f3;
    assign lane_lo = (state == ST_IDLE) ? req_addr[1:0] : lat_lo;

    lsu_lane u_lane (
        .f3         (lane_f3),
        .addr_lo    (lane_lo),
        .wdata      (req_wdata),
        .rdata_word (bus.bus_rdata),
        .be         (lane_be),
        .wdata_lane (lane_wdata),
        .load_data  (lane_load)
    );

    // A request that must complete with an error without touching the bus.
    always_comb begin
        req_bad = f3_illegal(req_f3);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_f3[1:0] == 2'b01) && req_addr[0]) begin
            req_bad = 1'b1;
        end
        if ((req_f3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) begin
            req_bad = 1'b1;
        end
`endif
    end

    // The counter runs across REQ and WAIT, so this fires on the TIMEOUT-th
    // cycle spent waiting on the bus.
    assign timeout_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));

    // Combinational in IDLE so the datapath freezes in the request cycle.
    assign stall = ((state == ST_IDLE) && req_valid) ||
                   (state == ST_REQ) || (state == ST_WAIT);

    // Main FSM with registered completion and bus outputs. Bus fields are
    // loaded on entry to REQ and cleared on leaving it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            lat_we        <= 1'b0;
            lat_f3        <= 3'b000;
            lat_lo        <= 2'b00;
            tmo_cnt       <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            rdata         <= 32'h0;
            bus.bus_req   <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_we    <= 1'b0;
            bus.bus_be    <= 4'b0000;
            bus.bus_wdata <= 32'h0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    err   <= 1'b0;
                    rdata <= 32'h0;
                    if (req_valid) begin
                        lat_we  <= req_we;
                        lat_f3  <= req_f3;
                        lat_lo  <= req_addr[1:0];
                        tmo_cnt <= '0;
                        if (req_bad) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state         <= ST_REQ;
                            bus.bus_req   <= 1'b1;
                            bus.bus_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            bus.bus_we    <= req_we;
                            bus.bus_be    <= lane_be;
                            bus.bus_wdata <= req_we ? lane_wdata : 32'h0;
                        end
                    end
                end
                ST_REQ: begin
                    if (timeout_hit || bus.bus_gnt) begin
                        bus.bus_req   <= 1'b0;
                        bus.bus_addr  <= '0;
                        bus.bus_we    <= 1'b0;
                        bus.bus_be    <= 4'b0000;
                        bus.bus_wdata <= 32'h0;
                    end
                    if (timeout_hit) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                        rdata <= 32'h0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (bus.bus_gnt) begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // A response arriving on the expiry cycle still counts.
                    if (bus.bus_rvalid) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        err   <= bus.bus_err;
                        rdata <= (bus.bus_err || lat_we) ? 32'h0 : lane_load;
                    end else if (timeout_hit) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                        rdata <= 32'h0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    err   <= 1'b0;
                    rdata <= 32'h0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_lsu_bus_bridge
// Self-checking bench for lsu_bus_bridge. The bench plays the bus slave with
// chosen grant/response delays and predicts completion cycle, error and load
// data from the access rules using plain arithmetic.
// ---------------------------------------------------------------------------
module tb_lsu_bus_bridge;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_f3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] last_rdata;
    logic        last_err;

    lsu_bus_bridge_if #(.ADDR_W(32)) bus_if ();

    lsu_bus_bridge #(
        .ADDR_W  (32),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_f3    (req_f3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .bus       (bus_if)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the run.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Reference rules, written from the access definitions.
    function automatic bit model_bad(input logic [2:0] f3, input logic [31:0] addr);
        bit bad;
        bad = (f3 == 3) || (f3 == 6) || (f3 == 7);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((f3 % 4) == 1 && (addr % 2) != 0) bad = 1;
        if ((f3 % 4) == 2 && (addr % 4) != 0) bad = 1;
`endif
        return bad;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        if ((f3 % 4) == 0) return 4'(1 << (addr % 4));
        if ((f3 % 4) == 1) return ((addr / 2) % 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if ((f3 % 4) == 0) return (wd % 256) * 32'h01010101;
        if ((f3 % 4) == 1) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        logic [31:0] b;
        logic [31:0] h;
        b = (word / (32'd1 << ((addr % 4) * 8))) % 256;
        h = (word / (32'd1 << (((addr / 2) % 2) * 16))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd5:    return h;
            3'd2:    return word;
            default: return 32'h0;
        endcase
    endfunction

    // Runs one access starting at a negedge: request in cycle 0, slave grants
    // on the (g+1)-th REQ cycle and responds r cycles into WAIT.
    task automatic apply_stimulus(input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [31:0] rword, input int g, input int r,
                                  input logic berr, input string tag);
        bit bad;
        bit tmo;
        bit granted;
        int done_cyc;
        int req_end;
        int cg;
        logic        exp_err;
        logic [31:0] exp_rd;

        bad = model_bad(f3, addr);
        if (bad) begin
            done_cyc = 1; req_end = 0; tmo = 0;
        end else if (g + 1 >= TIMEOUT) begin
            done_cyc = TIMEOUT + 1; req_end = TIMEOUT; tmo = 1;
        end else if (g + r + 2 <= TIMEOUT) begin
            done_cyc = g + r + 3; req_end = g + 1; tmo = 0;
        end else begin
            done_cyc = TIMEOUT + 1; req_end = g + 1; tmo = 1;
        end
        exp_err = bad || tmo || berr;
        exp_rd  = (exp_err || we) ? 32'h0 : model_load(f3, addr, rword);

        req_valid = 1'b1;
        req_we    = we;
        req_f3    = f3;
        req_addr  = addr;
        req_wdata = wd;
        #1;
        check_output({tag, "_stall0"}, 32'(stall), 32'd1);
        check_output({tag, "_done0"}, 32'(done), 32'd0);

        granted = 0;
        cg      = 0;
        for (int c = 1; c <= done_cyc; c++) begin
            @(negedge clk);
            bus_if.bus_gnt    = 1'b0;
            bus_if.bus_rvalid = 1'b0;
            bus_if.bus_err    = 1'b0;
            bus_if.bus_rdata  = $urandom;
            check_output({tag, "_done"}, 32'(done), 32'(c == done_cyc));
            check_output({tag, "_stall"}, 32'(stall), 32'(c < done_cyc));
            check_output({tag, "_busreq"}, 32'(bus_if.bus_req), 32'(c <= req_end));
            if (c == 1 && req_end >= 1) begin
                check_output({tag, "_addr"}, bus_if.bus_addr, addr & 32'hFFFFFFFC);
                check_output({tag, "_be"}, 32'(bus_if.bus_be), 32'(model_be(f3, addr)));
                check_output({tag, "_we"}, 32'(bus_if.bus_we), 32'(we));
                if (we) check_output({tag, "_wdata"}, bus_if.bus_wdata, model_wdata(f3, wd));
            end
            if (c == done_cyc) begin
                check_output({tag, "_err"}, 32'(err), 32'(exp_err));
                check_output({tag, "_rdata"}, rdata, exp_rd);
                last_rdata = rdata;
                last_err   = err;
            end else if (!granted && c <= req_end) begin
                if (c == g + 1) begin
                    bus_if.bus_gnt = 1'b1;
                    granted        = 1;
                    cg             = c;
                end else begin
                    // Responses while still requesting must be ignored.
                    bus_if.bus_rvalid = 1'($urandom % 2);
                    bus_if.bus_err    = 1'($urandom % 2);
                end
            end else if (granted && (c - cg - 1) == r) begin
                bus_if.bus_rvalid = 1'b1;
                bus_if.bus_rdata  = rword;
                bus_if.bus_err    = berr;
            end
        end
        req_valid         = 1'b0;
        bus_if.bus_gnt    = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_err    = 1'b0;
        @(negedge clk);
        check_output({tag, "_idle_done"}, 32'(done), 32'd0);
        check_output({tag, "_idle_stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        rst               = 1'b0;
        req_valid         = 1'b0;
        req_we            = 1'b0;
        req_f3            = 3'b000;
        req_addr          = 32'h0;
        req_wdata         = 32'h0;
        bus_if.bus_gnt    = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata  = 32'h0;
        bus_if.bus_err    = 1'b0;
        last_rdata        = 32'h0;
        last_err          = 1'b0;

        repeat (2) @(negedge clk);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_err", 32'(err), 32'd0);
        check_output("rst_rdata", rdata, 32'h0);
        check_output("rst_stall", 32'(stall), 32'd0);
        check_output("rst_busreq", 32'(bus_if.bus_req), 32'd0);
        check_output("rst_addr", bus_if.bus_addr, 32'h0);
        check_output("rst_be", 32'(bus_if.bus_be), 32'd0);
        check_output("rst_wdata", bus_if.bus_wdata, 32'h0);
        check_output("rst_we", 32'(bus_if.bus_we), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        apply_stimulus(1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0, "lw");
        check_output("lw_plan", last_rdata, 32'hDEADBEEF);
        apply_stimulus(1'b0, 3'd0, 32'h13, 32'h0, 32'h80123456, 0, 0, 1'b0, "lb");
        check_output("lb_plan", last_rdata, 32'hFFFFFF80);
        apply_stimulus(1'b0, 3'd4, 32'h13, 32'h0, 32'h80123456, 1, 2, 1'b0, "lbu");
        check_output("lbu_plan", last_rdata, 32'h00000080);
        apply_stimulus(1'b0, 3'd5, 32'h12, 32'h0, 32'hBEEF1234, 2, 1, 1'b0, "lhu");
        check_output("lhu_plan", last_rdata, 32'h0000BEEF);
        apply_stimulus(1'b0, 3'd1, 32'h10, 32'h0, 32'h1234F00D, 0, 3, 1'b0, "lh");
        check_output("lh_plan", last_rdata, 32'hFFFFF00D);
        apply_stimulus(1'b1, 3'd0, 32'h21, 32'hA5, 32'h0, 0, 0, 1'b0, "sb");
        check_output("sb_plan", last_rdata, 32'h0);
        apply_stimulus(1'b1, 3'd1, 32'h22, 32'h1234CAFE, 32'h0, 1, 1, 1'b0, "sh");
        apply_stimulus(1'b0, 3'd2, 32'h40, 32'h0, 32'h11111111, 100, 0, 1'b0, "tmo_gnt");
        check_output("tmo_gnt_err", 32'(last_err), 32'd1);
        apply_stimulus(1'b0, 3'd2, 32'h44, 32'h0, 32'h22222222, 5, 20, 1'b0, "tmo_wait");
        apply_stimulus(1'b0, 3'd2, 32'h48, 32'h0, 32'h33333333, 5, 9, 1'b0, "edge_rv");
        apply_stimulus(1'b0, 3'd2, 32'h4C, 32'h0, 32'h44444444, TIMEOUT - 1, 0, 1'b0, "edge_req");
        apply_stimulus(1'b0, 3'd2, 32'h50, 32'h0, 32'h55555555, 1, 2, 1'b1, "berr");
        check_output("berr_rdata", last_rdata, 32'h0);
        apply_stimulus(1'b0, 3'd2, 32'h02, 32'h0, 32'h66666666, 0, 0, 1'b0, "lw_mis");
        apply_stimulus(1'b1, 3'd1, 32'h05, 32'hBEEF, 32'h0, 0, 0, 1'b0, "sh_mis");
        apply_stimulus(1'b0, 3'd3, 32'h60, 32'h0, 32'h0, 0, 0, 1'b0, "ill3");
        apply_stimulus(1'b1, 3'd7, 32'h60, 32'h0, 32'h0, 0, 0, 1'b0, "ill7");

        // Reset while requesting: bus_req must drop without waiting for a clock.
        req_valid = 1'b1; req_we = 1'b0; req_f3 = 3'd2; req_addr = 32'h80;
        @(negedge clk);
        check_output("rreq_busreq_pre", 32'(bus_if.bus_req), 32'd1);
        #2;
        rst = 1'b0;
        req_valid = 1'b0;
        #1;
        check_output("rreq_busreq_async", 32'(bus_if.bus_req), 32'd0);
        check_output("rreq_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset while waiting, then a late response that must be ignored.
        req_valid = 1'b1; req_we = 1'b0; req_f3 = 3'd2; req_addr = 32'h84;
        @(negedge clk);
        bus_if.bus_gnt = 1'b1;
        @(negedge clk);
        bus_if.bus_gnt = 1'b0;
        check_output("rwait_stall_pre", 32'(stall), 32'd1);
        rst = 1'b0;
        req_valid = 1'b0;
        #1;
        check_output("rwait_done", 32'(done), 32'd0);
        check_output("rwait_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = 32'hFACEFACE;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_output("late_rv_done", 32'(done), 32'd0);
            check_output("late_rv_busreq", 32'(bus_if.bus_req), 32'd0);
            check_output("late_rv_stall", 32'(stall), 32'd0);
        end
        bus_if.bus_rvalid = 1'b0;
        apply_stimulus(1'b0, 3'd2, 32'h88, 32'h0, 32'h0BADF00D, 0, 0, 1'b0, "post_rst");

        for (int i = 0; i < 40; i++) begin
            logic       we;
            logic [2:0] f3;
            int         g;
            int         r;
            logic       berr;
            we = 1'($urandom % 2);
            if (we) begin
                case ($urandom % 6)
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd3;
                    4: f3 = 3'd6;
                    default: f3 = 3'd7;
                endcase
            end else begin
                f3 = 3'($urandom % 8);
            end
            g    = (($urandom % 8) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 5));
            r    = (($urandom % 8) == 0) ? int'($urandom_range(8, 16)) : int'($urandom_range(0, 5));
            berr = 1'(($urandom % 8) == 0);
            apply_stimulus(we, f3, $urandom, $urandom, $urandom, g, r, berr, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
